mux_1_3_route_ctrl: RTL

Packet-level routing controller for the 1-to-3 AXI-Stream mux. Accepts a per-packet destination command, steers one input stream through a registered output stage to one of three outputs or discards the packet, and never switches destination mid-packet. Per-channel stall watchdogs produce the 4-bit `axis_block_sigs` vector consumed by the mux deadlock monitor.

---
 rtl/mux_1_3_route_ctrl_pkg.sv | 40 ++++
 rtl/mux_1_3_route_ctrl_if.sv | 38 +++
 rtl/mux_1_3_route_ctrl_stall_counter.sv | 47 ++++
 rtl/mux_1_3_route_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mux_1_3_route_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_1_3_ctrl_pkg
//  Description : Shared types and constants for the 1-to-3 AXI-Stream route
//                controller: FSM state encoding, output count, drop selector
//                code, block-vector bit positions and a selector decoder.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_1_3_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_e;

  localparam int         NUM_OUT  = 3;
  localparam logic [1:0] SEL_DROP = 2'd3;

  // Bit positions inside axis_block_sigs
  localparam int BLK_IN   = 0;
  localparam int BLK_OUT0 = 1;
  localparam int BLK_W    = 1 + NUM_OUT;

  // Selector to one-hot output mask; the drop code maps to no output.
  function automatic logic [NUM_OUT-1:0] sel_onehot(input logic [1:0] sel);
    logic [NUM_OUT-1:0] mask;
    mask = '0;
    case (sel)
      2'd0:    mask = 3'b001;
      2'd1:    mask = 3'b010;
      2'd2:    mask = 3'b100;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_1_3_route_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_1_3_route_ctrl_if
//  Description : Command, input-stream and output-stream signals of the
//                route controller bundled into one interface.
//  Ports       : cfg_sel/cfg_valid/cfg_ready  - per-packet destination command
//                s_tvalid/s_tready/s_tdata/s_tlast - input stream
//                m_tvalid[3]/m_tready[3]/m_tdata/m_tlast - output streams
//                modport slave  : controller side
//                modport master : traffic source / sink side
//  Revision    : 1.0 - initial release
// ============================================================================
interface mux_1_3_route_ctrl_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        cfg_sel;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              s_tvalid;
  logic              s_tready;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tlast;
  logic [2:0]        m_tvalid;
  logic [2:0]        m_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tlast;

  modport slave (
    input  cfg_sel, cfg_valid, s_tvalid, s_tdata, s_tlast, m_tready,
    output cfg_ready, s_tready, m_tvalid, m_tdata, m_tlast
  );

  modport master (
    output cfg_sel, cfg_valid, s_tvalid, s_tdata, s_tlast, m_tready,
    input  cfg_ready, s_tready, m_tvalid, m_tdata, m_tlast
  );
endinterface
`default_nettype wire

// File: rtl/mux_1_3_route_ctrl_stall_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mux_1_3_stall_counter
//  Description : Counts consecutive cycles with cond high, saturating at
//                STALL_LIMIT; block is a registered flag raised once the
//                count has sat at the limit for a stalled cycle.
//  Ports       : clock - rising-edge clock
//                reset - asynchronous active-high reset
//                cond  - stall condition for this cycle
//                block - stall-limit reached
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_1_3_stall_counter #(
  parameter int STALL_LIMIT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic cond,
  output logic block
);

  localparam int                 c_cnt_w = $clog2(STALL_LIMIT + 1);
  localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STALL_LIMIT);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_block;

  // The flag is qualified with cond so it drops on the first cycle after
  // progress instead of lingering one extra cycle behind the counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_block <= 1'b0;
    end else begin
      if (!cond) begin
        r_cnt <= '0;
      end else if (r_cnt != c_limit) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_block <= cond && (r_cnt == c_limit);
    end
  end

  assign block = r_block;

endmodule
`default_nettype wire

// File: rtl/mux_1_3_route_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mux_1_3_route_ctrl
//  Description : Packet-level routing controller for the 1-to-3 AXI-Stream
//                mux. A destination command selects one of three outputs or
//                discard for the next packet; beats pass through a one-entry
//                registered output stage tagged with its destination. Four
//                stall watchdogs drive axis_block_sigs.
//  Ports       : clock, reset       - clock / async active-high reset
//                bus (slave)        - command, input and output streams
//                axis_block_sigs[4] - bit0 input stall, bits1..3 output stall
//                drop_count         - discarded packets, saturating
//                busy               - packet in flight or output held
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_1_3_route_ctrl
  import mux_1_3_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  mux_1_3_route_ctrl_if.slave  bus,
  output logic [BLK_W-1:0]     axis_block_sigs,
  output logic [CNT_W-1:0]     drop_count,
  output logic                 busy
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [1:0]         r_cur_sel;
  logic               r_obuf_full;
  logic [DATA_W-1:0]  r_obuf_data;
  logic               r_obuf_last;
  logic [1:0]         r_obuf_sel;
  logic [CNT_W-1:0]   r_drop_count;

  logic               w_cfg_ready;
  logic               w_s_tready;
  logic               w_drain;
  logic               w_load;
  logic               w_drop_last;
  logic [NUM_OUT-1:0] w_m_tvalid;
  logic [BLK_W-1:0]   w_stall;

  assign w_m_tvalid = r_obuf_full ? sel_onehot(r_obuf_sel) : '0;
  assign w_drain    = |(w_m_tvalid & bus.m_tready);

  always_comb begin
    w_state_nxt = r_state;
    w_cfg_ready = 1'b0;
    w_s_tready  = 1'b0;
    case (r_state)
      IDLE: begin
        // Holding back the command while data is buffered keeps a new
        // destination from overtaking the previous packet's tail.
        w_cfg_ready = !r_obuf_full;
        if (bus.cfg_valid && w_cfg_ready) begin
          w_state_nxt = (bus.cfg_sel == SEL_DROP) ? DROP : ROUTE;
        end
      end
      ROUTE: begin
        w_s_tready = !r_obuf_full || w_drain;
        if (bus.s_tvalid && w_s_tready && bus.s_tlast) begin
          w_state_nxt = IDLE;
        end
      end
      DROP: begin
        w_s_tready = 1'b1;
        if (bus.s_tvalid && bus.s_tlast) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_load      = (r_state == ROUTE) && bus.s_tvalid && w_s_tready;
  assign w_drop_last = (r_state == DROP) && bus.s_tvalid && bus.s_tlast;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cur_sel <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && bus.cfg_valid && w_cfg_ready) begin
        r_cur_sel <= bus.cfg_sel;
      end
    end
  end

  // Single-entry output register; a load in the same cycle as a drain
  // simply replaces the departing beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_obuf_full <= 1'b0;
      r_obuf_data <= '0;
      r_obuf_last <= 1'b0;
      r_obuf_sel  <= 2'd0;
    end else if (w_load) begin
      r_obuf_full <= 1'b1;
      r_obuf_data <= bus.s_tdata;
      r_obuf_last <= bus.s_tlast;
      r_obuf_sel  <= r_cur_sel;
    end else if (w_drain) begin
      r_obuf_full <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_drop_count <= '0;
    end else if (w_drop_last && (r_drop_count != {CNT_W{1'b1}})) begin
      r_drop_count <= r_drop_count + 1'b1;
    end
  end

  assign w_stall[BLK_IN] = bus.s_tvalid && !w_s_tready;

  generate
    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out_stall
      assign w_stall[BLK_OUT0 + k] = w_m_tvalid[k] && !bus.m_tready[k];
    end
    for (genvar i = 0; i < BLK_W; i++) begin : g_stall
      mux_1_3_stall_counter #(
        .STALL_LIMIT (STALL_LIMIT)
      ) u_stall (
        .clock (clock),
        .reset (reset),
        .cond  (w_stall[i]),
        .block (axis_block_sigs[i])
      );
    end
  endgenerate

  assign bus.cfg_ready = w_cfg_ready;
  assign bus.s_tready  = w_s_tready;
  assign bus.m_tvalid  = w_m_tvalid;
  assign bus.m_tdata   = r_obuf_data;
  assign bus.m_tlast   = r_obuf_last;
  assign drop_count    = r_drop_count;
  assign busy          = (r_state != IDLE) || r_obuf_full;

endmodule
`default_nettype wire
